biquad_io_tx: RTL and testbench

BIQUAD_IO_TX -- requirements
Module: biquad_io_tx

---
 rtl/biquad_io_tx.sv | 162 ++++++++++++++++
 tb/tb_biquad_io_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/biquad_io_tx.sv
// Biquad output transmitter: buffers filtered samples and holds each on the user pads for HOLD_CYCLES clocks.
// Define BIQUAD_TX_MARKER_EN to append an 00FF/0000 end-of-frame marker after every s_last sample.
module biquad_io_tx #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] io_out,
    output logic [DATA_W-1:0] io_oeb,
    output logic              busy
);

`ifdef BIQUAD_TX_MARKER_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
`ifdef BIQUAD_TX_MARKER_EN
    localparam logic [1:0] ST_MARK0 = 2'd2;
    localparam logic [1:0] ST_MARK1 = 2'd3;
    localparam logic [DATA_W-1:0] MARK0_WORD = DATA_W'(16'h00FF);
`endif

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic [ENTRY_W-1:0] entry_in, head;
    logic               push, pop, fifo_ne, hold_done;
    logic [1:0]         state;
    logic [7:0]         hold_cnt;
`ifdef BIQUAD_TX_MARKER_EN
    logic               cur_last;
    assign entry_in = {s_last, s_data};
`else
    logic               unused_last;
    assign unused_last = s_last;
    assign entry_in    = s_data;
`endif

    assign head      = mem[rd_ptr];
    assign push      = s_valid && s_ready;
    assign fifo_ne   = (count != '0);
    assign hold_done = (hold_cnt == 8'd0);
    assign busy      = fifo_ne || (state != ST_IDLE);
    assign io_oeb    = {DATA_W{~resetb}};

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    // A pop always coincides with loading the popped word onto the pads.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = fifo_ne;
            ST_HOLD: begin
                pop = hold_done && fifo_ne;
`ifdef BIQUAD_TX_MARKER_EN
                if (cur_last)
                    pop = 1'b0;
`endif
            end
`ifdef BIQUAD_TX_MARKER_EN
            ST_MARK1: pop = hold_done && fifo_ne;
`endif
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= entry_in;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_next;
            s_ready <= (count_next < DEPTH_C);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state    <= ST_IDLE;
            hold_cnt <= 8'd0;
            io_out   <= '0;
`ifdef BIQUAD_TX_MARKER_EN
            cur_last <= 1'b0;
`endif
        end else if (pop) begin
            io_out   <= head[DATA_W-1:0];
            hold_cnt <= HOLD_LOAD;
            state    <= ST_HOLD;
`ifdef BIQUAD_TX_MARKER_EN
            cur_last <= head[DATA_W];
`endif
        end else begin
            case (state)
                ST_IDLE: ;
                ST_HOLD: begin
                    if (!hold_done)
                        hold_cnt <= hold_cnt - 8'd1;
`ifdef BIQUAD_TX_MARKER_EN
                    else if (cur_last) begin
                        state    <= ST_MARK0;
                        io_out   <= MARK0_WORD;
                        hold_cnt <= HOLD_LOAD;
                        cur_last <= 1'b0;
                    end
`endif
                    else
                        state <= ST_IDLE;
                end
`ifdef BIQUAD_TX_MARKER_EN
                ST_MARK0: begin
                    if (!hold_done)
                        hold_cnt <= hold_cnt - 8'd1;
                    else begin
                        state    <= ST_MARK1;
                        io_out   <= '0;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                ST_MARK1: begin
                    if (!hold_done)
                        hold_cnt <= hold_cnt - 8'd1;
                    else
                        state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_io_tx.sv
// Directed bench for biquad_io_tx; follows BIQUAD_TX_MARKER_EN to pick marker or plain expectations.
module tb_biquad_io_tx;

    logic        clock = 1'b0;
    logic        resetb;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        busy;

    int n_compared = 0;
    int n_failed   = 0;

    biquad_io_tx #(
        .DATA_W      (16),
        .FIFO_DEPTH  (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clock   (clock),
        .resetb  (resetb),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .io_out  (io_out),
        .io_oeb  (io_oeb),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Streams 1..10 with s_valid held high; words load one clock after the first accept and each lasts 8 clocks.
    task automatic applyStimulus(input bit use_last, input logic [15:0] prev_word);
        int          next_val;
        int          accepted;
        bit          acc;
        logic [15:0] exp_word;
        next_val = 1;
        accepted = 0;
        for (int k = 0; k < 100; k++) begin
            s_valid = (next_val <= 10);
            s_data  = 16'(next_val);
            s_last  = use_last && (next_val == 10);
            acc     = s_valid && s_ready;
            step();
            if (acc) begin
                accepted++;
                next_val++;
            end
            if (k == 0)
                exp_word = prev_word;
            else if (k <= 80)
                exp_word = 16'((k - 1) / 8 + 1);
`ifdef BIQUAD_TX_MARKER_EN
            else if (use_last && k <= 88)
                exp_word = 16'h00FF;
            else if (use_last)
                exp_word = 16'h0000;
`endif
            else
                exp_word = 16'h000A;
            checkOutput($sformatf("burst_word_k%0d", k), 32'(io_out), 32'(exp_word));
            if (k == 3)
                checkOutput("burst_ready_before_full", 32'(s_ready), 32'd1);
            if (k == 4)
                checkOutput("burst_ready_full", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("burst_accepted", 32'(accepted), 32'd10);
        checkOutput("burst_busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        resetb  = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0005;
        s_last  = 1'b0;

        for (int i = 0; i < 10; i++)
            step();
        checkOutput("rst_oeb", 32'(io_oeb), 32'h0000FFFF);
        checkOutput("rst_io_out", 32'(io_out), 32'd0);
        checkOutput("rst_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        resetb  = 1'b1;
        s_valid = 1'b0;
        #1;
        checkOutput("rel_oeb", 32'(io_oeb), 32'd0);
        checkOutput("rel_ready_pre_edge", 32'(s_ready), 32'd0);
        step();
        checkOutput("rel_ready_first_edge", 32'(s_ready), 32'd1);
        checkOutput("rel_nothing_accepted", 32'(busy), 32'd0);

        // Single sample into an idle block.
        s_valid = 1'b1;
        s_data  = 16'h0001;
        step();
        s_valid = 1'b0;
        checkOutput("single_not_yet", 32'(io_out), 32'd0);
        checkOutput("single_busy", 32'(busy), 32'd1);
        step();
        checkOutput("single_shown", 32'(io_out), 32'h1);
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput($sformatf("single_hold_%0d", i), 32'(io_out), 32'h1);
            checkOutput($sformatf("single_busy_%0d", i), 32'(busy), 32'd1);
        end
        step();
        checkOutput("single_idle_busy", 32'(busy), 32'd0);
        checkOutput("single_retained", 32'(io_out), 32'h1);

        applyStimulus(1'b0, 16'h0001);
        applyStimulus(1'b1, 16'h000A);

        // Reset during the hold of word 3 while two entries remain buffered.
        for (int k = 0; k < 21; k++) begin
            s_valid = (k < 5);
            s_data  = 16'(16'h0011 + k);
            step();
        end
        s_valid = 1'b0;
        checkOutput("mid_word3", 32'(io_out), 32'h13);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        resetb = 1'b0;
        #1;
        checkOutput("mid_rst_io_out", 32'(io_out), 32'd0);
        checkOutput("mid_rst_oeb", 32'(io_oeb), 32'h0000FFFF);
        checkOutput("mid_rst_ready", 32'(s_ready), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        step();
        step();
        resetb = 1'b1;
        #1;
        checkOutput("mid_rel_oeb", 32'(io_oeb), 32'd0);
        step();
        checkOutput("mid_rel_ready", 32'(s_ready), 32'd1);
        checkOutput("mid_rel_empty", 32'(busy), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'h0077;
        step();
        s_valid = 1'b0;
        checkOutput("mid_push_pending", 32'(io_out), 32'd0);
        step();
        checkOutput("mid_first_word", 32'(io_out), 32'h77);
        for (int i = 0; i < 8; i++)
            step();
        checkOutput("mid_idle_after", 32'(busy), 32'd0);
        checkOutput("mid_retained", 32'(io_out), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
